pir_alarm_ctrl_n: RTL and testbench
===================================

// Module: pir_alarm_ctrl_n
// PURPOSE
//   Parametrised N-channel PIR motion-alarm controller, successor to the fixed 3-sensor alarm FSM.
//   Per-sensor threshold debounce, sticky per-channel LEDs, a timed buzzer and a post-alarm holdoff.
//   Also tracks peak reading, peak source channel and a saturating alarm-event count.
//   Sits between the sensor sampling front-end and the LED/buzzer/display drivers.
// PARAMETERS
//   N_SENSORS      3    number of PIR channels (>=1)
//   SENSOR_W       7    bits per sensor reading (unsigned)
//   THRESHOLD      50   channel is "hot" when reading >= THRESHOLD
//   HIT_COUNT      3    consecutive hot samples needed to qualify a channel (>=1)
//   BUZZ_CYCLES    100  buzzer on-time in clk cycles (>=1)
//   HOLDOFF_CYCLES 8    re-arm holdoff after alarm, in clk cycles (>=1)
//   EVT_W          8    width of event_count
// PORTS
//   clk           in   1                    system clock, rising edge
//   rst           in   1                    asynchronous reset, active-high
//   arm           in   1                    1 = system armed, 0 = disarm (the "turn" switch)
//   stop_alarm    in   1                    user acknowledge; ends alarm early
//   clear_stats   in   1                    synchronous clear of peak_value/peak_sensor/event_count
//   sensor_data   in   N_SENSORS*SENSOR_W   packed readings; channel i = [i*SENSOR_W +: SENSOR_W]
//   led           out  N_SENSORS            sticky per-channel triggered indicator
//   buzzer        out  1                    alarm sounder
//   active_count  out  $clog2(N_SENSORS+1)  popcount of led
//   peak_value    out  SENSOR_W             max reading seen during alarms
//   peak_sensor   out  $clog2(N_SENSORS+1)  channel index+1 of peak_value; 0 = none
//   event_count   out  EVT_W                number of ARMED->ALARM entries, saturating
//   state_o       out  2                    0 DISARMED, 1 ARMED, 2 ALARM, 3 HOLDOFF
// BEHAVIOUR
//   - All outputs registered. Reset: state DISARMED, all outputs 0, all internal counters 0.
//   - hot_i = reading_i >= THRESHOLD. hit_cnt_i saturates at HIT_COUNT-1: +1 while hot, clears to 0 when not.
//     It counts only in ARMED and ALARM; it is forced to 0 in DISARMED and HOLDOFF.
//   - qual_i = hot_i && (hit_cnt_i == HIT_COUNT-1). A channel qualifies on its HIT_COUNT-th consecutive hot edge.
//   - DISARMED: led, buzzer, active_count held 0. arm=1 -> ARMED.
//   - ARMED: arm=0 -> DISARMED. Else if any qual_i -> ALARM.
//     That same edge sets buzzer=1, led=qual mask, event_count+1 (saturating) and clears the alarm timer.
//   - ALARM: led |= qual mask each cycle; active_count = popcount(next led). Timer +1 per cycle.
//     Exit priority: arm=0 -> DISARMED; else stop_alarm=1 -> HOLDOFF; else timer==BUZZ_CYCLES-1 -> HOLDOFF.
//     Without stop, buzzer stays high exactly BUZZ_CYCLES cycles.
//   - HOLDOFF: on entry edge led, buzzer, active_count clear to 0. Stays exactly HOLDOFF_CYCLES cycles, then ARMED.
//     arm=0 -> DISARMED at any time. Sensors are ignored in HOLDOFF.
//   - Peak: evaluated on every edge where next state is ALARM (including the entry edge).
//     Candidate = max reading over all channels; ties go to the lowest index.
//     Update only if candidate > peak_value (strict). peak_sensor = index+1.
//   - Peak/event statistics survive DISARMED. They clear only on rst or clear_stats.
//     clear_stats wins over a same-cycle update.
//   - rst mid-ALARM: buzzer and led drop asynchronously; FSM restarts in DISARMED even if arm=1.
//     ARMED is reached on the first edge after rst deasserts.
// TESTING (defaults unless stated)
//   1. arm=1; ch1=60 for 2 cycles, then 10 -> stays ARMED; buzzer=0; event_count=0.
//   2. ch2=70 steady from edge k -> ALARM, buzzer=1, led=3'b010 after edge k+2.
//      buzzer high 100 cycles, then HOLDOFF for 8 cycles, then ARMED; event_count=1; peak=70; peak_sensor=2.
//   3. ch1=ch3=90 simultaneously -> led=3'b101; active_count=2; peak_value=90; peak_sensor=1 (tie).
//   4. stop_alarm pulse at alarm cycle 10 -> led=0, buzzer=0 next edge; HOLDOFF 8 cycles; ch2=70 held -> re-alarm 3 edges after ARMED.
//   5. arm=0 and stop_alarm=1 same ALARM cycle -> DISARMED; stats retained; clear_stats -> peak_value=0, event_count=0.
//   6. rst at alarm cycle 40 -> outputs 0 immediately; stats cleared. EVT_W=2: 5 alarms -> event_count=3.

Source files
------------

// File: rtl/pir_alarm_ctrl_n.sv
// N-channel PIR motion-alarm controller: per-channel debounce, sticky LEDs, timed buzzer,
// post-alarm holdoff, plus peak reading / source and saturating alarm-event statistics.
module pir_alarm_ctrl_n #(
  parameter int unsigned N_SENSORS      = 3,
  parameter int unsigned SENSOR_W       = 7,
  parameter int unsigned THRESHOLD      = 50,
  parameter int unsigned HIT_COUNT      = 3,
  parameter int unsigned BUZZ_CYCLES    = 100,
  parameter int unsigned HOLDOFF_CYCLES = 8,
  parameter int unsigned EVT_W          = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arm,
  input  logic                               stop_alarm,
  input  logic                               clear_stats,
  input  logic [N_SENSORS*SENSOR_W-1:0]      sensor_data,
  output logic [N_SENSORS-1:0]               led,
  output logic                               buzzer,
  output logic [$clog2(N_SENSORS+1)-1:0]     active_count,
  output logic [SENSOR_W-1:0]                peak_value,
  output logic [$clog2(N_SENSORS+1)-1:0]     peak_sensor,
  output logic [EVT_W-1:0]                   event_count,
  output logic [1:0]                         state_o
);

  localparam int unsigned IDX_W = $clog2(N_SENSORS + 1);
  localparam int unsigned HIT_W = $clog2(HIT_COUNT + 1);
  localparam int unsigned TMR_W = $clog2(BUZZ_CYCLES + 1);
  localparam int unsigned HLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [SENSOR_W-1:0] THR       = SENSOR_W'(THRESHOLD);
  localparam logic [HIT_W-1:0]    HIT_LAST  = HIT_W'(HIT_COUNT - 1);
  localparam logic [TMR_W-1:0]    BUZZ_LAST = TMR_W'(BUZZ_CYCLES - 1);
  localparam logic [HLD_W-1:0]    HOLD_LAST = HLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ALARM    = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [HIT_W-1:0]     hit_cnt [N_SENSORS];
  logic [TMR_W-1:0]     timer;
  logic [HLD_W-1:0]     hold_cnt;
  logic [N_SENSORS-1:0] hot, qual, led_n;
  logic [IDX_W-1:0]     led_pop, cand_idx;
  logic [SENSOR_W-1:0]  rd, cand_val;
  logic                 counting;

  assign counting = (state == S_ARMED) || (state == S_ALARM);
  assign state_o  = state;

  // Per-channel hot/qualify flags and the max reading (lowest index wins ties).
  always_comb begin
    hot      = '0;
    qual     = '0;
    rd       = '0;
    cand_val = sensor_data[SENSOR_W-1:0];
    cand_idx = IDX_W'(1);
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      rd      = sensor_data[i*SENSOR_W +: SENSOR_W];
      hot[i]  = (rd >= THR);
      qual[i] = hot[i] && (hit_cnt[i] == HIT_LAST);
      if (rd > cand_val) begin
        cand_val = rd;
        cand_idx = IDX_W'(i + 1);
      end
    end
  end

  // LED mask if the next state is ALARM: fresh mask on entry, accumulated while staying.
  always_comb begin
    led_n   = (state == S_ALARM) ? (led | qual) : qual;
    led_pop = '0;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      led_pop = led_pop + IDX_W'(led_n[i]);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_DISARMED: if (arm) state_n = S_ARMED;
      S_ARMED: begin
        if (!arm)       state_n = S_DISARMED;
        else if (|qual) state_n = S_ALARM;
      end
      S_ALARM: begin
        if (!arm)                                state_n = S_DISARMED;
        else if (stop_alarm || timer == BUZZ_LAST) state_n = S_HOLDOFF;
      end
      default: begin
        if (!arm)                   state_n = S_DISARMED;
        else if (hold_cnt == HOLD_LAST) state_n = S_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_DISARMED;
      timer        <= '0;
      hold_cnt     <= '0;
      led          <= '0;
      buzzer       <= 1'b0;
      active_count <= '0;
      peak_value   <= '0;
      peak_sensor  <= '0;
      event_count  <= '0;
      for (int i = 0; i < int'(N_SENSORS); i++) hit_cnt[i] <= '0;
    end else begin
      state <= state_n;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (counting && hot[i])
          hit_cnt[i] <= (hit_cnt[i] == HIT_LAST) ? hit_cnt[i] : hit_cnt[i] + HIT_W'(1);
        else
          hit_cnt[i] <= '0;
      end
      timer    <= (state == S_ALARM)   ? timer + TMR_W'(1)    : '0;
      hold_cnt <= (state == S_HOLDOFF) ? hold_cnt + HLD_W'(1) : '0;

      // Indicators are live only while the alarm is active.
      if (state_n == S_ALARM) begin
        led          <= led_n;
        buzzer       <= 1'b1;
        active_count <= led_pop;
      end else begin
        led          <= '0;
        buzzer       <= 1'b0;
        active_count <= '0;
      end

      if (clear_stats) begin
        peak_value  <= '0;
        peak_sensor <= '0;
        event_count <= '0;
      end else begin
        if (state == S_ARMED && state_n == S_ALARM && event_count != '1)
          event_count <= event_count + EVT_W'(1);
        if (state_n == S_ALARM && cand_val > peak_value) begin
          peak_value  <= cand_val;
          peak_sensor <= cand_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_pir_alarm_ctrl_n.sv
// Bench for pir_alarm_ctrl_n: directed scenarios plus a random phase, all checked every
// cycle against a streak/countdown reference model; a second instance uses EVT_W=2.
module tb_pir_alarm_ctrl_n;

  localparam int unsigned N     = 3;
  localparam int unsigned W     = 7;
  localparam int unsigned THR   = 50;
  localparam int unsigned HIT   = 3;
  localparam int unsigned BUZZ  = 100;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned IW    = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst, arm, stop_alarm, clear_stats;
  logic [N*W-1:0] sensor_data;

  logic [N-1:0]  led, led_s;
  logic          buzzer, buzzer_s;
  logic [IW-1:0] active_count, active_count_s, peak_sensor, peak_sensor_s;
  logic [W-1:0]  peak_value, peak_value_s;
  logic [7:0]    event_count;
  logic [1:0]    event_count_s;
  logic [1:0]    state_o, state_o_s;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           m_mode;
  int           streak [N];
  int           buzz_left, hold_left;
  int           ev, pk_val, pk_src;
  logic [N-1:0] m_led;

  pir_alarm_ctrl_n dut (
    .clk(clk), .rst(rst), .arm(arm), .stop_alarm(stop_alarm), .clear_stats(clear_stats),
    .sensor_data(sensor_data), .led(led), .buzzer(buzzer), .active_count(active_count),
    .peak_value(peak_value), .peak_sensor(peak_sensor), .event_count(event_count),
    .state_o(state_o)
  );

  pir_alarm_ctrl_n #(.EVT_W(2)) dut_s (
    .clk(clk), .rst(rst), .arm(arm), .stop_alarm(stop_alarm), .clear_stats(clear_stats),
    .sensor_data(sensor_data), .led(led_s), .buzzer(buzzer_s), .active_count(active_count_s),
    .peak_value(peak_value_s), .peak_sensor(peak_sensor_s), .event_count(event_count_s),
    .state_o(state_o_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; buzz_left = 0; hold_left = 0;
    ev = 0; pk_val = 0; pk_src = 0; m_led = '0;
    for (int i = 0; i < int'(N); i++) streak[i] = 0;
  endtask

  // Model: unbounded hot streaks, remaining-cycle countdowns, event count kept unsaturated.
  task automatic model_step();
    int           r [N];
    logic [N-1:0] q;
    int           nm, best;
    bit           counting;
    if (rst) begin
      model_reset();
      return;
    end
    counting = (m_mode == 1 || m_mode == 2);
    q = '0;
    for (int i = 0; i < int'(N); i++) begin
      r[i] = int'(sensor_data[i*W +: W]);
      if (counting && r[i] >= int'(THR) && streak[i] >= int'(HIT) - 1) q[i] = 1'b1;
    end
    case (m_mode)
      0:       nm = arm ? 1 : 0;
      1:       nm = !arm ? 0 : (q != '0) ? 2 : 1;
      2:       nm = !arm ? 0 : (stop_alarm || buzz_left == 1) ? 3 : 2;
      default: nm = !arm ? 0 : (hold_left == 1) ? 1 : 3;
    endcase
    for (int i = 0; i < int'(N); i++)
      streak[i] = (counting && r[i] >= int'(THR)) ? streak[i] + 1 : 0;
    if (nm == 2) begin
      if (m_mode == 1) begin
        m_led = q; buzz_left = int'(BUZZ); ev++;
      end else begin
        m_led = m_led | q; buzz_left--;
      end
      best = 0;
      for (int i = 1; i < int'(N); i++) if (r[i] > r[best]) best = i;
      if (r[best] > pk_val) begin
        pk_val = r[best]; pk_src = best + 1;
      end
    end else begin
      m_led = '0;
    end
    if (nm == 3) hold_left = (m_mode == 3) ? hold_left - 1 : int'(HOLD);
    if (clear_stats) begin
      ev = 0; pk_val = 0; pk_src = 0;
    end
    m_mode = nm;
  endtask

  task automatic check_all();
    chk("state",        32'(state_o),        32'(m_mode));
    chk("led",          32'(led),            32'(m_led));
    chk("buzzer",       32'(buzzer),         32'(m_mode == 2));
    chk("active_count", 32'(active_count),   32'($countones(m_led)));
    chk("peak_value",   32'(peak_value),     32'(pk_val));
    chk("peak_sensor",  32'(peak_sensor),    32'(pk_src));
    chk("event_count",  32'(event_count),    32'((ev > 255) ? 255 : ev));
    chk("s_state",      32'(state_o_s),      32'(m_mode));
    chk("s_led",        32'(led_s),          32'(m_led));
    chk("s_buzzer",     32'(buzzer_s),       32'(m_mode == 2));
    chk("s_active",     32'(active_count_s), 32'($countones(m_led)));
    chk("s_peak_value", 32'(peak_value_s),   32'(pk_val));
    chk("s_peak_src",   32'(peak_sensor_s),  32'(pk_src));
    chk("s_event_sat",  32'(event_count_s),  32'((ev > 3) ? 3 : ev));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  function automatic int cold();
    return int'($urandom_range(THR - 1, 0));
  endfunction

  function automatic int warm();
    return int'($urandom_range(127, THR));
  endfunction

  task automatic set_rd(input int a, input int b, input int c);
    sensor_data = {W'(c), W'(b), W'(a)};
  endtask

  initial begin
    int bz, hd;
    rst = 1'b1; arm = 1'b0; stop_alarm = 1'b0; clear_stats = 1'b0;
    set_rd(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // Arm, then a 2-sample hot burst on ch1 must not alarm.
    arm = 1'b1; set_rd(cold(), cold(), cold());
    tick(1);
    chk("t1_armed", 32'(state_o), 32'd1);
    set_rd(60, cold(), cold());
    tick(2);
    set_rd(10, cold(), cold());
    tick(3);
    chk("t1_no_buzz", 32'(buzzer), 32'd0);
    chk("t1_no_evt", 32'(event_count), 32'd0);

    // ch2=70 steady: alarm on the third edge, 100-cycle buzzer, 8-cycle holdoff.
    set_rd(cold(), 70, cold());
    tick(2);
    chk("t2_pre_alarm", 32'(state_o), 32'd1);
    tick(1);
    chk("t2_alarm", 32'(state_o), 32'd2);
    chk("t2_led", 32'(led), 32'b010);
    set_rd(cold(), cold(), cold());
    bz = 1; hd = 0;
    for (int k = 0; k < 115; k++) begin
      tick(1);
      if (buzzer === 1'b1) bz++;
      if (state_o === 2'd3) hd++;
    end
    chk("t2_buzz_len", 32'(bz), 32'(BUZZ));
    chk("t2_hold_len", 32'(hd), 32'(HOLD));
    chk("t2_rearmed", 32'(state_o), 32'd1);
    chk("t2_evt", 32'(event_count), 32'd1);
    chk("t2_peak", 32'(peak_value), 32'd70);
    chk("t2_peak_src", 32'(peak_sensor), 32'd2);

    // Simultaneous ch1/ch3 = 90: both LEDs, tie goes to ch1.
    set_rd(90, cold(), 90);
    tick(3);
    chk("t3_led", 32'(led), 32'b101);
    chk("t3_active", 32'(active_count), 32'd2);
    chk("t3_peak", 32'(peak_value), 32'd90);
    chk("t3_peak_src", 32'(peak_sensor), 32'd1);
    stop_alarm = 1'b1; tick(1); stop_alarm = 1'b0;
    set_rd(cold(), cold(), cold());
    tick(8);
    chk("t3_rearmed", 32'(state_o), 32'd1);

    // Stop at alarm cycle 10, ch2 held hot through holdoff, re-alarm 3 edges after ARMED.
    set_rd(cold(), 70, cold());
    tick(3);
    tick(9);
    stop_alarm = 1'b1; tick(1); stop_alarm = 1'b0;
    chk("t4_led_clr", 32'(led), 32'd0);
    chk("t4_buzz_clr", 32'(buzzer), 32'd0);
    tick(7);
    chk("t4_still_hold", 32'(state_o), 32'd3);
    tick(1);
    chk("t4_armed", 32'(state_o), 32'd1);
    tick(2);
    chk("t4_not_yet", 32'(state_o), 32'd1);
    tick(1);
    chk("t4_realarm", 32'(state_o), 32'd2);

    // arm=0 beats stop_alarm; stats survive, then clear_stats wipes them.
    tick(3);
    arm = 1'b0; stop_alarm = 1'b1;
    tick(1);
    stop_alarm = 1'b0;
    chk("t5_disarmed", 32'(state_o), 32'd0);
    chk("t5_peak_kept", 32'(peak_value), 32'd90);
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    chk("t5_peak_clr", 32'(peak_value), 32'd0);
    chk("t5_evt_clr", 32'(event_count), 32'd0);

    // Five short alarms: 8-bit counter reads 5, 2-bit counter saturates at 3.
    arm = 1'b1; set_rd(cold(), cold(), cold());
    tick(1);
    for (int k = 0; k < 5; k++) begin
      set_rd(cold(), cold(), warm());
      tick(3);
      stop_alarm = 1'b1; set_rd(cold(), cold(), cold());
      tick(1);
      stop_alarm = 1'b0;
      tick(8);
    end
    chk("t6_evt5", 32'(event_count), 32'd5);
    chk("t6_evt_sat", 32'(event_count_s), 32'd3);

    // Asynchronous reset at alarm cycle 40.
    set_rd(warm(), cold(), cold());
    tick(3);
    set_rd(cold(), cold(), cold());
    tick(39);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_buzz", 32'(buzzer), 32'd0);
    chk("t6_rst_evt", 32'(event_count), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    chk("t6_rst_armed", 32'(state_o), 32'd1);

    // Random phase.
    for (int k = 0; k < 3000; k++) begin
      arm         = ($urandom_range(99, 0) != 0);
      stop_alarm  = ($urandom_range(39, 0) == 0);
      clear_stats = ($urandom_range(199, 0) == 0);
      sensor_data = (N*W)'($urandom);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
